uart_rx_ctrl: RTL and testbench

Controller sitting between the RxUnit receiver and the host/bus side. It owns the receiver's parity_type/baud_rate configuration and applies host changes only while the receiver is idle. It captures each completed frame on the rising edge of done_flag, filters errored frames, and buffers good bytes in a small FIFO with a valid/ready output. It also keeps sticky overrun status and a saturating error counter.

---
 rtl/uart_pkg.sv | 37 +++
 rtl/uart_sync_fifo.sv | 69 ++++++
 rtl/uart_rx_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive controller slice: baud and parity
// codes, error bit positions, controller state codes and FIFO entry width.
// Optional build macro RX_ERR_KEEP_EN widens FIFO entries to carry the
// 3-bit error tag alongside the data byte.
package uart_pkg;

  localparam logic [1:0] BAUD_2400  = 2'b00;
  localparam logic [1:0] BAUD_4800  = 2'b01;
  localparam logic [1:0] BAUD_9600  = 2'b10;
  localparam logic [1:0] BAUD_19200 = 2'b11;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  localparam int ERR_PARITY = 0;
  localparam int ERR_START  = 1;
  localparam int ERR_STOP   = 2;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RECV    = 3'd1;
  localparam logic [2:0] ST_CAPTURE = 3'd2;
  localparam logic [2:0] ST_RECONF  = 3'd3;
  localparam logic [2:0] ST_GUARD   = 3'd4;

`ifdef RX_ERR_KEEP_EN
  localparam int ENTRY_W = 11;
`else
  localparam int ENTRY_W = 8;
`endif

  // Increment an 8-bit counter, holding at its maximum value.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with a registered head output. Pointers carry one extra
// bit so full and empty are told apart when the address bits match.
// A push while full is taken only if a pop happens in the same cycle.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      wr_nxt;
  logic [AW:0]      rd_nxt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign wr_nxt  = do_push ? wr_ptr + (AW+1)'(1) : wr_ptr;
  assign rd_nxt  = do_pop  ? rd_ptr + (AW+1)'(1) : rd_ptr;

  // Advance read and write pointers on accepted pushes and pops.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
    end
  end

  // Store accepted bytes; storage needs no reset since pointers gate reads.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

  // Keep the head register equal to the entry that will be at the front
  // after this edge, bypassing the write data when it becomes the head.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rdata <= '0;
    end else if (wr_nxt == rd_nxt) begin
      rdata <= '0;
    end else if (do_push && (rd_nxt[AW-1:0] == wr_ptr[AW-1:0])) begin
      rdata <= wdata;
    end else begin
      rdata <= mem[rd_nxt[AW-1:0]];
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Host-side controller for the RxUnit receiver. Owns parity/baud config and
// applies host writes only while the receiver is idle, followed by a guard
// interval. Captures frames on rising edges of done, buffers good bytes in
// a FIFO, and keeps sticky overrun and a saturating error count.
// Build macro RX_ERR_KEEP_EN: errored frames are also queued with their tag.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int         DEPTH      = 8,
  parameter int         CFG_GUARD  = 16,
  parameter logic [1:0] RST_BAUD   = BAUD_9600,
  parameter logic [1:0] RST_PARITY = PAR_NONE
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   cfg_wr,
  input  logic [1:0]             cfg_parity,
  input  logic [1:0]             cfg_baud,
  output logic                   cfg_busy,
  output logic [1:0]             parity_type,
  output logic [1:0]             baud_rate,
  input  logic                   rx_active_flag,
  input  logic                   rx_done_flag,
  input  logic [2:0]             rx_error_flag,
  input  logic [7:0]             rx_data,
  output logic [7:0]             m_data,
  output logic [2:0]             m_err,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overrun,
  output logic [7:0]             err_cnt,
  input  logic                   clear_stats
);

  localparam int GW = (CFG_GUARD > 1) ? $clog2(CFG_GUARD) : 1;

  logic [2:0]         state;
  logic [2:0]         state_nxt;
  logic               done_q;
  logic               done_edge;
  logic               pend_valid;
  logic [1:0]         pend_parity;
  logic [1:0]         pend_baud;
  logic [GW-1:0]      guard_cnt;
  logic               is_capture;
  logic               frame_err;
  logic               push_req;
  logic               pop;
  logic               drop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] fifo_wdata;
  logic [ENTRY_W-1:0] fifo_head;

  assign done_edge  = rx_done_flag & ~done_q;
  assign is_capture = (state == ST_CAPTURE);
  assign frame_err  = |rx_error_flag;
  assign cfg_busy   = pend_valid | (state == ST_RECONF) | (state == ST_GUARD);
  assign m_valid    = ~fifo_empty;
  assign pop        = m_valid & m_ready;
  assign drop       = push_req & fifo_full & ~pop;
  assign m_data     = fifo_head[7:0];

`ifdef RX_ERR_KEEP_EN
  assign push_req   = is_capture;
  assign fifo_wdata = {rx_error_flag, rx_data};
  assign m_err      = fifo_head[10:8];
`else
  assign push_req   = is_capture & ~frame_err;
  assign fifo_wdata = rx_data;
  assign m_err      = 3'b000;
`endif

  // Remember the previous done level so only rising edges start a capture.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      done_q <= 1'b0;
    end else begin
      done_q <= rx_done_flag;
    end
  end

  // Next-state logic; a pending config wins over a new frame when idle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (pend_valid && !rx_active_flag) begin
          state_nxt = ST_RECONF;
        end else if (done_edge) begin
          state_nxt = ST_CAPTURE;
        end else if (rx_active_flag) begin
          state_nxt = ST_RECV;
        end
      end
      ST_RECV: begin
        if (done_edge) begin
          state_nxt = ST_CAPTURE;
        end else if (!rx_active_flag) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_CAPTURE: state_nxt = ST_IDLE;
      ST_RECONF:  state_nxt = ST_GUARD;
      ST_GUARD: begin
        if (guard_cnt == '0) begin
          state_nxt = ST_IDLE;
        end
      end
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Controller state register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Hold the latest host config write and apply it in the reconfig cycle.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pend_valid  <= 1'b0;
      pend_parity <= RST_PARITY;
      pend_baud   <= RST_BAUD;
      parity_type <= RST_PARITY;
      baud_rate   <= RST_BAUD;
    end else begin
      if (cfg_wr) begin
        pend_valid  <= 1'b1;
        pend_parity <= cfg_parity;
        pend_baud   <= cfg_baud;
      end else if (state == ST_RECONF) begin
        pend_valid <= 1'b0;
      end
      if (state == ST_RECONF) begin
        parity_type <= pend_parity;
        baud_rate   <= pend_baud;
      end
    end
  end

  // Guard interval counter loaded on apply and run down while guarding.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      guard_cnt <= '0;
    end else if (state == ST_RECONF) begin
      guard_cnt <= GW'(CFG_GUARD - 1);
    end else if ((state == ST_GUARD) && (guard_cnt != '0)) begin
      guard_cnt <= guard_cnt - GW'(1);
    end
  end

  // Sticky overrun and saturating error count; a clear request wins.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      overrun <= 1'b0;
      err_cnt <= 8'd0;
    end else if (clear_stats) begin
      overrun <= 1'b0;
      err_cnt <= 8'd0;
    end else begin
      if (drop) begin
        overrun <= 1'b1;
      end
      if (is_capture && frame_err) begin
        err_cnt <= sat_inc8(err_cnt);
      end
    end
  end

  uart_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push_req),
    .pop     (pop),
    .wdata   (fifo_wdata),
    .rdata   (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl. Stimulus tasks push predicted bytes
// into a queue; a negedge monitor compares the FIFO head, level and stats.
// Honours RX_ERR_KEEP_EN when the design is built with it.
module tb_uart_rx_ctrl;

  localparam int DEPTH     = 8;
  localparam int CFG_GUARD = 16;

  logic       clock;
  logic       reset_n;
  logic       cfg_wr;
  logic [1:0] cfg_parity;
  logic [1:0] cfg_baud;
  logic       cfg_busy;
  logic [1:0] parity_type;
  logic [1:0] baud_rate;
  logic       rx_active_flag;
  logic       rx_done_flag;
  logic [2:0] rx_error_flag;
  logic [7:0] rx_data;
  logic [7:0] m_data;
  logic [2:0] m_err;
  logic       m_valid;
  logic       m_ready;
  logic [3:0] fifo_level;
  logic       overrun;
  logic [7:0] err_cnt;
  logic       clear_stats;

  int          errors = 0;
  int          checks = 0;
  logic [10:0] sb[$];
  bit          mdl_ovr = 0;
  int          mdl_errcnt = 0;
  int          ready_mode = 0;
  bit          mon_en = 0;
  bit          count_en = 0;
  int          busy_new = 0;

  uart_rx_ctrl #(
    .DEPTH      (DEPTH),
    .CFG_GUARD  (CFG_GUARD),
    .RST_BAUD   (2'b10),
    .RST_PARITY (2'b00)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .cfg_wr         (cfg_wr),
    .cfg_parity     (cfg_parity),
    .cfg_baud       (cfg_baud),
    .cfg_busy       (cfg_busy),
    .parity_type    (parity_type),
    .baud_rate      (baud_rate),
    .rx_active_flag (rx_active_flag),
    .rx_done_flag   (rx_done_flag),
    .rx_error_flag  (rx_error_flag),
    .rx_data        (rx_data),
    .m_data         (m_data),
    .m_err          (m_err),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .fifo_level     (fifo_level),
    .overrun        (overrun),
    .err_cnt        (err_cnt),
    .clear_stats    (clear_stats)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void checkOutput(string name, int unsigned act, int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Consumer ready, driven a little after each rising edge.
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clock);
      #2;
      case (ready_mode)
        0:       m_ready = 1'b0;
        1:       m_ready = 1'b1;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Scoreboard monitor: the queue is the reference FIFO contents.
  initial begin
    forever begin
      @(negedge clock);
      if (mon_en && reset_n) begin
        checkOutput("mon_level", fifo_level, sb.size());
        checkOutput("mon_valid", m_valid, (sb.size() != 0) ? 1 : 0);
        checkOutput("mon_overrun", overrun, mdl_ovr);
        checkOutput("mon_err_cnt", err_cnt, mdl_errcnt);
        if (sb.size() != 0) begin
          checkOutput("mon_data", m_data, sb[0][7:0]);
          checkOutput("mon_err", m_err, sb[0][10:8]);
          if (m_ready) void'(sb.pop_front());
        end
      end
    end
  end

  // Counts guard cycles during which the new config is already visible.
  initial begin
    forever begin
      @(negedge clock);
      if (count_en && cfg_busy && parity_type == 2'b01 && baud_rate == 2'b11) busy_new++;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic modelCapture(input logic [7:0] data, input logic [2:0] err, input bit clr);
    bit         keep;
    logic [2:0] tag;
`ifdef RX_ERR_KEEP_EN
    keep = 1'b1;
    tag  = err;
`else
    keep = (err == 3'b000);
    tag  = 3'b000;
`endif
    if (keep) begin
      if (sb.size() < DEPTH) sb.push_back({tag, data});
      else mdl_ovr = 1'b1;
    end
    if (err != 3'b000 && mdl_errcnt < 255) mdl_errcnt++;
    if (clr) begin
      mdl_ovr    = 1'b0;
      mdl_errcnt = 0;
    end
  endtask

  // One received frame: optional active phase, done pulse, capture cycle.
  task automatic applyStimulus(input logic [7:0] data, input logic [2:0] err, input bit quick,
                               input bit expect_cap, input bit clr, input bit rdy_cap);
    int saved;
    saved         = ready_mode;
    rx_data       = data;
    rx_error_flag = err;
    if (!quick) begin
      rx_active_flag = 1'b1;
      step();
      step();
    end
    rx_done_flag = 1'b1;
    step();
    rx_done_flag   = 1'b0;
    rx_active_flag = 1'b0;
    clear_stats    = clr;
    if (rdy_cap) ready_mode = 1;
    @(negedge clock);
    #1;
    if (expect_cap) modelCapture(data, err, clr);
    else if (clr) begin
      mdl_ovr    = 1'b0;
      mdl_errcnt = 0;
    end
    step();
    clear_stats = 1'b0;
    if (rdy_cap) ready_mode = saved;
  endtask

  task automatic clearStats();
    clear_stats = 1'b1;
    @(negedge clock);
    #1;
    mdl_ovr    = 1'b0;
    mdl_errcnt = 0;
    step();
    clear_stats = 1'b0;
  endtask

  task automatic abortFrame();
    rx_active_flag = 1'b1;
    step();
    step();
    rx_active_flag = 1'b0;
    step();
    step();
  endtask

  task automatic drain();
    ready_mode = 1;
    for (int i = 0; i < 40 && sb.size() != 0; i++) step();
    ready_mode = 0;
    step();
    checkOutput("drain_level", fifo_level, 0);
  endtask

  initial begin
    int  sw_at;
    reset_n        = 1'b0;
    cfg_wr         = 1'b0;
    cfg_parity     = 2'b00;
    cfg_baud       = 2'b00;
    rx_active_flag = 1'b0;
    rx_done_flag   = 1'b0;
    rx_error_flag  = 3'b000;
    rx_data        = 8'h00;
    clear_stats    = 1'b0;
    step();
    step();
    step();
    checkOutput("rst_parity", parity_type, 2'b00);
    checkOutput("rst_baud", baud_rate, 2'b10);
    checkOutput("rst_valid", m_valid, 0);
    checkOutput("rst_level", fifo_level, 0);
    checkOutput("rst_data", m_data, 0);
    checkOutput("rst_busy", cfg_busy, 0);
    checkOutput("rst_err_cnt", err_cnt, 0);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    step();

    // Single good frame and its two-clock latency.
    rx_data        = 8'hB5;
    rx_error_flag  = 3'b000;
    rx_active_flag = 1'b1;
    step();
    step();
    rx_done_flag = 1'b1;
    step();
    checkOutput("t1_valid_early", m_valid, 0);
    rx_done_flag   = 1'b0;
    rx_active_flag = 1'b0;
    @(negedge clock);
    #1;
    modelCapture(8'hB5, 3'b000, 1'b0);
    step();
    checkOutput("t1_valid", m_valid, 1);
    checkOutput("t1_data", m_data, 8'hB5);
    checkOutput("t1_level", fifo_level, 1);
    ready_mode = 1;
    step();
    checkOutput("t1_level_pop", fifo_level, 0);
    ready_mode = 0;
    step();

    // Config write while receiving, applied after the frame, then guard.
    checkOutput("t2_busy_idle", cfg_busy, 0);
    rx_active_flag = 1'b1;
    step();
    cfg_wr     = 1'b1;
    cfg_parity = 2'b01;
    cfg_baud   = 2'b11;
    step();
    cfg_wr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput("t2_hold_parity", parity_type, 2'b00);
      checkOutput("t2_hold_baud", baud_rate, 2'b10);
      checkOutput("t2_busy", cfg_busy, 1);
      step();
    end
    rx_active_flag = 1'b0;
    count_en       = 1'b1;
    sw_at          = -1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (sw_at < 0 && parity_type == 2'b01 && baud_rate == 2'b11) sw_at = i;
      if (i == 5) begin
        rx_active_flag = 1'b1;
        rx_data        = 8'h77;
        rx_error_flag  = 3'b100;
      end
      if (i == 7) rx_done_flag = 1'b1;
      if (i == 8) begin
        rx_done_flag   = 1'b0;
        rx_active_flag = 1'b0;
      end
    end
    count_en = 1'b0;
    checkOutput("t2_switch_in_time", (sw_at >= 0 && sw_at <= 3) ? 1 : 0, 1);
    checkOutput("t2_guard_cycles", busy_new, CFG_GUARD);
    checkOutput("t2_busy_end", cfg_busy, 0);
    checkOutput("t2_parity", parity_type, 2'b01);
    checkOutput("t2_baud", baud_rate, 2'b11);
    checkOutput("t2_err_cnt", err_cnt, 0);

    // Fill past full, then a full-plus-pop frame is accepted.
    ready_mode = 0;
    for (int i = 1; i <= 9; i++) applyStimulus(8'(i), 3'b000, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("t3_level", fifo_level, 8);
    checkOutput("t3_overrun", overrun, 1);
    checkOutput("t3_head", m_data, 8'h01);
    applyStimulus(8'h09, 3'b000, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("t3_level_swap", fifo_level, 8);
    checkOutput("t3_head_swap", m_data, 8'h02);
    drain();
    clearStats();
    checkOutput("t3_overrun_clr", overrun, 0);

    // Errored frame.
    applyStimulus(8'h3C, 3'b001, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("t4_err_cnt", err_cnt, 1);
`ifdef RX_ERR_KEEP_EN
    checkOutput("t4_level", fifo_level, 1);
    checkOutput("t4_m_err", m_err, 3'b001);
`else
    checkOutput("t4_level", fifo_level, 0);
`endif
    drain();

    // Error counter saturation and clear winning over an increment.
    ready_mode = 2;
    for (int i = 0; i < 300; i++)
      applyStimulus(8'($urandom), 3'($urandom_range(1, 7)), 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("t5_err_sat", err_cnt, 255);
    applyStimulus(8'h11, 3'b100, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("t5_err_clr", err_cnt, 0);
    drain();

    // Reset with a full FIFO, overrun set, error counted and config pending.
    for (int i = 0; i < 9; i++) applyStimulus(8'(8'hA0 + i), 3'b000, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h55, 3'b010, 1'b1, 1'b1, 1'b0, 1'b0);
    rx_active_flag = 1'b1;
    cfg_wr         = 1'b1;
    cfg_parity     = 2'b10;
    cfg_baud       = 2'b00;
    step();
    cfg_wr  = 1'b0;
    reset_n = 1'b0;
    step();
    sb.delete();
    mdl_ovr        = 1'b0;
    mdl_errcnt     = 0;
    rx_active_flag = 1'b0;
    checkOutput("t6_level", fifo_level, 0);
    checkOutput("t6_overrun", overrun, 0);
    checkOutput("t6_err_cnt", err_cnt, 0);
    checkOutput("t6_parity", parity_type, 2'b00);
    checkOutput("t6_baud", baud_rate, 2'b10);
    checkOutput("t6_busy", cfg_busy, 0);
    checkOutput("t6_data", m_data, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    checkOutput("t6_parity_hold", parity_type, 2'b00);
    checkOutput("t6_baud_hold", baud_rate, 2'b10);
    checkOutput("t6_busy_hold", cfg_busy, 0);

    // Randomized traffic with random consumer backpressure.
    ready_mode = 2;
    for (int n = 0; n < 80; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) abortFrame();
      else if (r == 1) clearStats();
      else begin
        logic [2:0] e;
        e = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
        applyStimulus(8'($urandom), e, 1'($urandom_range(0, 1)), 1'b1,
                      ($urandom_range(0, 15) == 0), 1'b0);
      end
      for (int g = $urandom_range(0, 2); g > 0; g--) step();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
